// File: rtl/haze_pkg.sv
// Shared encodings for the execute-stage control-transfer logic.
package haze_pkg;

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'd0,
    KIND_JAL    = 2'd1,
    KIND_JALR   = 2'd2,
    KIND_RSVD   = 2'd3
  } branch_kind_t;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  localparam int unsigned c_LINK_STRIDE = 4;

endpackage

// File: rtl/set_less.sv
// Signed and unsigned set-less-than, zero-extended to XLEN like an slt/sltu result.
module set_less #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  output logic [XLEN-1:0] o_IsLess,
  output logic [XLEN-1:0] o_IsLessUnsigned
);

  assign o_IsLess         = {{(XLEN-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
  assign o_IsLessUnsigned = {{(XLEN-1){1'b0}}, (i_A < i_B)};

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: one registered op per handshake, producing
// taken/target/link/mispredict plus saturating branch and mispredict counters.
module branch_resolve
  import haze_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     i_Clock,
  input  logic                     i_ResetN,
  input  logic                     i_Flush,
  input  logic                     i_Valid,
  output logic                     o_Ready,
  input  logic [XLEN-1:0]          i_A,
  input  logic [XLEN-1:0]          i_B,
  input  logic [XLEN-1:0]          i_PC,
  input  logic [XLEN-1:0]          i_Offset,
  input  logic [2:0]               i_Funct3,
  input  logic [1:0]               i_Kind,
  input  logic                     i_PredictedTaken,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic                     o_Taken,
  output logic [XLEN-1:0]          o_Target,
  output logic [XLEN-1:0]          o_Link,
  output logic                     o_Mispredict,
  output logic                     o_Illegal,
  output logic                     o_Misaligned,
  output logic [COUNTER_WIDTH-1:0] o_BranchCount,
  output logic [COUNTER_WIDTH-1:0] o_MispredictCount
);

  logic [XLEN-1:0] is_less, is_less_u, jalr_sum;
  logic            eq, accept;
  logic            taken_d, illegal_d, mispredict_d;
  logic [XLEN-1:0] target_d;

  logic                     valid_q, taken_q, mispredict_q, illegal_q;
  logic [XLEN-1:0]          target_q, link_q;
  logic [COUNTER_WIDTH-1:0] branch_cnt_q, mispredict_cnt_q;

  set_less #(.XLEN(XLEN)) u_set_less (
    .i_A              (i_A),
    .i_B              (i_B),
    .o_IsLess         (is_less),
    .o_IsLessUnsigned (is_less_u)
  );

  // Only bit 0 of the set_less results carries the comparison.
  logic unused_less_hi;
  assign unused_less_hi = ^{is_less[XLEN-1:1], is_less_u[XLEN-1:1]};

  assign eq       = (i_A == i_B);
  assign jalr_sum = i_A + i_Offset;
  assign o_Ready  = !valid_q || i_Ready;
  assign accept   = i_Valid && o_Ready && !i_Flush;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    target_d  = i_PC + i_Offset;
    case (branch_kind_t'(i_Kind))
      KIND_BRANCH: begin
        case (branch_funct3_t'(i_Funct3))
          F3_BEQ:  taken_d = eq;
          F3_BNE:  taken_d = !eq;
          F3_BLT:  taken_d = is_less[0];
          F3_BGE:  taken_d = !is_less[0];
          F3_BLTU: taken_d = is_less_u[0];
          F3_BGEU: taken_d = !is_less_u[0];
          default: illegal_d = 1'b1;
        endcase
      end
      KIND_JAL:  taken_d = 1'b1;
      KIND_JALR: begin
        taken_d  = 1'b1;
        target_d = {jalr_sum[XLEN-1:1], 1'b0};
      end
      KIND_RSVD: illegal_d = 1'b1;
    endcase
    mispredict_d = !illegal_d && (taken_d ^ i_PredictedTaken);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      valid_q <= 1'b0;
    end else if (i_Flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (i_Ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      taken_q      <= 1'b0;
      target_q     <= '0;
      link_q       <= '0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (accept) begin
      taken_q      <= taken_d;
      target_q     <= target_d;
      link_q       <= i_PC + XLEN'(c_LINK_STRIDE);
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
    end
  end

  // Counters saturate at all-ones and then simply hold.
  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (accept) begin
      if (branch_cnt_q != '1) begin
        branch_cnt_q <= branch_cnt_q + 1'b1;
      end
      if (mispredict_d && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
      end
    end
  end

  assign o_Valid           = valid_q;
  assign o_Taken           = taken_q;
  assign o_Target          = target_q;
  assign o_Link            = link_q;
  assign o_Mispredict      = mispredict_q;
  assign o_Illegal         = illegal_q;
  assign o_Misaligned      = taken_q && target_q[1];
  assign o_BranchCount     = branch_cnt_q;
  assign o_MispredictCount = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: a reference model predicts each accepted op,
// the monitor compares results when the DUT completes a handshake.
module tb_branch_resolve;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic            i_Clock = 1'b0;
  logic            i_ResetN, i_Flush, i_Valid, i_Ready, i_PredictedTaken;
  logic [XLEN-1:0] i_A, i_B, i_PC, i_Offset;
  logic [2:0]      i_Funct3;
  logic [1:0]      i_Kind;
  logic            o_Ready, o_Valid, o_Taken, o_Mispredict, o_Illegal, o_Misaligned;
  logic [XLEN-1:0] o_Target, o_Link;
  logic [CW-1:0]   o_BranchCount, o_MispredictCount;

  branch_resolve #(.XLEN(XLEN), .COUNTER_WIDTH(CW)) dut (
    .i_Clock           (i_Clock),
    .i_ResetN          (i_ResetN),
    .i_Flush           (i_Flush),
    .i_Valid           (i_Valid),
    .o_Ready           (o_Ready),
    .i_A               (i_A),
    .i_B               (i_B),
    .i_PC              (i_PC),
    .i_Offset          (i_Offset),
    .i_Funct3          (i_Funct3),
    .i_Kind            (i_Kind),
    .i_PredictedTaken  (i_PredictedTaken),
    .o_Valid           (o_Valid),
    .i_Ready           (i_Ready),
    .o_Taken           (o_Taken),
    .o_Target          (o_Target),
    .o_Link            (o_Link),
    .o_Mispredict      (o_Mispredict),
    .o_Illegal         (o_Illegal),
    .o_Misaligned      (o_Misaligned),
    .o_BranchCount     (o_BranchCount),
    .o_MispredictCount (o_MispredictCount)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            mispredict;
    logic            illegal;
    logic            misaligned;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] m_bc, m_mc;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [XLEN-1:0] a, b, pc, off,
                                 input logic [2:0] f3, input logic [1:0] kind,
                                 input logic pred);
    exp_t e;
    logic [XLEN-1:0] s;
    e.taken   = 1'b0;
    e.illegal = 1'b0;
    e.target  = pc + off;
    e.link    = pc + 32'd4;
    case (kind)
      2'd0: case (f3)
        3'b000: e.taken = (a == b);
        3'b001: e.taken = (a != b);
        3'b100: e.taken = ($signed(a) <  $signed(b));
        3'b101: e.taken = ($signed(a) >= $signed(b));
        3'b110: e.taken = (a <  b);
        3'b111: e.taken = (a >= b);
        default: e.illegal = 1'b1;
      endcase
      2'd1: e.taken = 1'b1;
      2'd2: begin
        e.taken  = 1'b1;
        s        = a + off;
        e.target = s & 32'hFFFF_FFFE;
      end
      default: e.illegal = 1'b1;
    endcase
    e.misaligned = e.taken && e.target[1];
    e.mispredict = e.illegal ? 1'b0 : (e.taken != pred);
    return e;
  endfunction

  // Monitor: samples at the falling edge, what the next rising edge will act on.
  always @(negedge i_Clock) begin
    exp_t e;
    logic exp_ready;
    if (!i_ResetN) begin
      sb.delete();
      m_bc = '0;
      m_mc = '0;
    end else begin
      exp_ready = (sb.size() == 0) || i_Ready;
      check("o_valid_model", o_Valid, sb.size() != 0);
      check("o_ready_model", o_Ready, exp_ready);
      if (o_Valid && i_Ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("taken",      o_Taken,      e.taken);
        check("target",     o_Target,     e.target);
        check("link",       o_Link,       e.link);
        check("mispredict", o_Mispredict, e.mispredict);
        check("illegal",    o_Illegal,    e.illegal);
        check("misaligned", o_Misaligned, e.misaligned);
        check("branch_cnt", o_BranchCount, m_bc);
        check("mispr_cnt",  o_MispredictCount, m_mc);
      end
      if (i_Valid && exp_ready && !i_Flush) begin
        e = model(i_A, i_B, i_PC, i_Offset, i_Funct3, i_Kind, i_PredictedTaken);
        sb.push_back(e);
        if (m_bc != '1) m_bc = m_bc + 1'b1;
        if (e.mispredict && m_mc != '1) m_mc = m_mc + 1'b1;
      end
      if (i_Flush) sb.delete();
    end
  end

  task automatic send(input logic [XLEN-1:0] a, b, pc, off, input logic [2:0] f3,
                      input logic [1:0] kind, input logic pred);
    int   n;
    logic done;
    i_A = a; i_B = b; i_PC = pc; i_Offset = off;
    i_Funct3 = f3; i_Kind = kind; i_PredictedTaken = pred;
    i_Valid = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge i_Clock);
      if (o_Ready) done = 1'b1;
      n++;
    end
    if (!done) check("send_accept_timeout", o_Ready, 1'b1);
    @(posedge i_Clock); #1;
    i_Valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic            snap_taken;
    logic [XLEN-1:0] snap_target, snap_link;
    logic [CW-1:0]   snap_bc, snap_mc;

    i_ResetN = 1'b0; i_Flush = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1;
    i_A = '0; i_B = '0; i_PC = '0; i_Offset = '0;
    i_Funct3 = '0; i_Kind = '0; i_PredictedTaken = 1'b0;
    #2;
    check("rst_valid",  o_Valid, 1'b0);
    check("rst_taken",  o_Taken, 1'b0);
    check("rst_target", o_Target, '0);
    check("rst_link",   o_Link, '0);
    check("rst_bc",     o_BranchCount, '0);
    check("rst_mc",     o_MispredictCount, '0);
    repeat (3) @(posedge i_Clock);
    #1 i_ResetN = 1'b1;

    // Signed vs unsigned compare of the same operands
    send(32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 3'b100, 2'd0, 1'b0);
    check("t1_valid",  o_Valid, 1'b1);
    check("t1_taken",  o_Taken, 1'b1);
    check("t1_target", o_Target, 32'h120);
    check("t1_mispr",  o_Mispredict, 1'b1);
    check("t1_mc",     o_MispredictCount, 4'd1);
    send(32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 3'b110, 2'd0, 1'b0);
    check("t2_taken", o_Taken, 1'b0);
    check("t2_mispr", o_Mispredict, 1'b0);
    check("t2_link",  o_Link, 32'h104);

    // JALR low-bit clearing and misalignment
    send(32'h1003, 32'h0, 32'h200, 32'h4, 3'b000, 2'd2, 1'b1);
    check("t3_target", o_Target, 32'h1006);
    check("t3_misal",  o_Misaligned, 1'b1);
    send(32'h1001, 32'h0, 32'h200, 32'h0, 3'b000, 2'd2, 1'b1);
    check("t3b_target", o_Target, 32'h1000);
    check("t3b_misal",  o_Misaligned, 1'b0);

    // Back-to-back random ops, including illegal encodings and equal operands
    for (int i = 0; i < 8; i++) begin
      logic [XLEN-1:0] a, b;
      a = $urandom;
      b = (i % 3 == 0) ? a : $urandom;
      send(a, b, {$urandom_range(0, 32'hFFFF), 2'b00}, $urandom,
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Backpressure: hold while a new op waits
    i_Ready = 1'b0;
    snap_taken = o_Taken; snap_target = o_Target; snap_link = o_Link;
    i_A = 32'h5; i_B = 32'h5; i_PC = 32'h3000; i_Offset = 32'h40;
    i_Funct3 = 3'b000; i_Kind = 2'd0; i_PredictedTaken = 1'b0; i_Valid = 1'b1;
    repeat (3) begin
      @(negedge i_Clock);
      check("stall_ready",  o_Ready, 1'b0);
      check("stall_taken",  o_Taken, snap_taken);
      check("stall_target", o_Target, snap_target);
      check("stall_link",   o_Link, snap_link);
    end
    @(posedge i_Clock); #1;
    i_Ready = 1'b1;
    @(negedge i_Clock);
    check("release_ready", o_Ready, 1'b1);
    @(posedge i_Clock); #1;
    i_Valid = 1'b0;
    check("release_next_target", o_Target, 32'h3040);

    // Flush while holding a result, then flush against a would-be accept
    send(32'h7, 32'h9, 32'h4000, 32'h10, 3'b001, 2'd0, 1'b1);
    i_Ready = 1'b0;
    snap_bc = o_BranchCount; snap_mc = o_MispredictCount;
    i_Valid = 1'b1; i_Flush = 1'b1;
    @(posedge i_Clock); #1;
    i_Flush = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1;
    check("flush_valid", o_Valid, 1'b0);
    check("flush_bc",    o_BranchCount, snap_bc);
    check("flush_mc",    o_MispredictCount, snap_mc);
    i_Kind = 2'd1; i_PredictedTaken = 1'b0; i_Valid = 1'b1; i_Flush = 1'b1;
    @(posedge i_Clock); #1;
    i_Flush = 1'b0; i_Valid = 1'b0;
    check("flush_wins_valid", o_Valid, 1'b0);
    check("flush_wins_bc",    o_BranchCount, snap_bc);
    check("flush_wins_mc",    o_MispredictCount, snap_mc);

    // Saturation
    for (int i = 0; i < 20; i++) begin
      send(32'h0, 32'h0, 32'h8000 + 32'(i * 4), 32'h8, 3'b000, 2'd1, 1'(i % 2));
    end
    check("sat_bc", o_BranchCount, 4'hF);
    @(negedge i_Clock);

    // Asynchronous reset mid-stream
    i_Valid = 1'b1; i_Kind = 2'd1;
    @(posedge i_Clock); #3;
    i_ResetN = 1'b0;
    #1;
    check("arst_valid",  o_Valid, 1'b0);
    check("arst_taken",  o_Taken, 1'b0);
    check("arst_target", o_Target, '0);
    check("arst_bc",     o_BranchCount, '0);
    check("arst_mc",     o_MispredictCount, '0);
    i_Valid = 1'b0;
    @(posedge i_Clock); #1;
    i_ResetN = 1'b1;
    repeat (2) @(posedge i_Clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
